// File: rtl/jk_count_sequencer.sv
// jk_count_sequencer
//   Excitation/control stage for an external bank of WIDTH JK flip-flops.
//   It reads the bank's Q outputs (q_fb) and drives per-bit J/K so that the
//   bank counts modulo MOD: up, down, load, or hold. A shadow register tracks
//   the state the bank should hold, and a sticky flag records any divergence.
//
// Ports
//   clk       clock, shared with the JK bank (same edge)
//   reset     async active-high reset, shared with the JK bank
//   en        advance enable (0 = hold)
//   mode      00 hold, 01 up, 10 down, 11 load
//   load_val  load value, clamped to MOD-1
//   q_fb      Q outputs of the JK bank
//   j_out     J inputs to the bank (bit i -> flip-flop i)
//   k_out     K inputs to the bank
//   expected  shadow of the bank state after the last edge
//   tc        registered one-cycle wrap pulse
//   illegal   combinational, q_fb >= MOD
//   err       sticky mismatch/illegal flag, cleared only by reset

// Per-bit excitation. Only set/reset/hold are used; J=K=1 (toggle) is never
// produced, so a glitchy bank cannot run away on a stale toggle.
module jk_excite_bit (
  input  logic q,
  input  logic n,
  output logic j,
  output logic k
);
  assign j = ~q &  n;
  assign k =  q & ~n;
endmodule

module jk_count_sequencer #(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic [WIDTH-1:0] expected,
  output logic             tc,
  output logic             illegal,
  output logic             err
);

  localparam logic [1:0] M_HOLD = 2'b00;
  localparam logic [1:0] M_UP   = 2'b01;
  localparam logic [1:0] M_DN   = 2'b10;
  localparam logic [1:0] M_LOAD = 2'b11;

  // The modulus may equal 2^WIDTH, so it needs one extra bit.
  localparam logic [WIDTH:0]   MOD_V = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD-1);

  logic [WIDTH-1:0] nxt;
  logic             tc_nxt;
  logic             load_ovr;

  assign illegal  = {1'b0, q_fb} >= MOD_V;
  assign load_ovr = {1'b0, load_val} >= MOD_V;

  // Next bank state. Wraps compare against MOD-1 / 0 explicitly instead of
  // relying on natural WIDTH-bit overflow.
  always_comb begin
    nxt    = q_fb;
    tc_nxt = 1'b0;
    if (en) begin
      case (mode)
        M_UP: begin
          if (illegal)            nxt = '0;
          else if (q_fb == MAX_V) begin nxt = '0; tc_nxt = 1'b1; end
          else                    nxt = q_fb + 1'b1;
        end
        M_DN: begin
          if (illegal)            nxt = '0;
          else if (q_fb == '0)    begin nxt = MAX_V; tc_nxt = 1'b1; end
          else                    nxt = q_fb - 1'b1;
        end
        M_LOAD:  nxt = load_ovr ? MAX_V : load_val;
        M_HOLD:  nxt = q_fb;
        default: nxt = q_fb;
      endcase
    end
  end

  jk_excite_bit u_bit [WIDTH-1:0] (
    .q (q_fb),
    .n (nxt),
    .j (j_out),
    .k (k_out)
  );

  // Checker samples pre-edge values: q_fb and expected both describe the
  // state produced by the previous edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      expected <= '0;
      tc       <= 1'b0;
      err      <= 1'b0;
    end else begin
      expected <= nxt;
      tc       <= tc_nxt;
      err      <= err | (q_fb != expected) | illegal;
    end
  end

endmodule

// File: tb/tb_jk_count_sequencer.sv
module tb_jk_count_sequencer;
  localparam int WIDTH = 4;
  localparam int MOD   = 10;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             en = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic [WIDTH-1:0] load_val = '0;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] j_out, k_out, expected;
  logic             tc, illegal, err;

  // bank override used to inject an illegal state
  logic             ovr = 1'b0;
  logic [WIDTH-1:0] ovr_val = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  jk_count_sequencer #(.WIDTH(WIDTH), .MOD(MOD)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .mode     (mode),
    .load_val (load_val),
    .q_fb     (q_fb),
    .j_out    (j_out),
    .k_out    (k_out),
    .expected (expected),
    .tc       (tc),
    .illegal  (illegal),
    .err      (err)
  );

  // JK flip-flop bank model
  always @(posedge clk or posedge reset) begin
    if (reset) q_fb <= '0;
    else if (ovr) q_fb <= ovr_val;
    else begin
      for (int i = 0; i < WIDTH; i++) begin
        case ({j_out[i], k_out[i]})
          2'b10:   q_fb[i] <= 1'b1;
          2'b01:   q_fb[i] <= 1'b0;
          2'b11:   q_fb[i] <= ~q_fb[i];
          default: q_fb[i] <= q_fb[i];
        endcase
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    chk("rst_expected", expected, 0);
    chk("rst_tc", tc, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    reset = 1'b0;

    // 1: count up across the wrap
    en = 1'b1; mode = 2'b01;
    for (int i = 1; i <= 12; i++) begin
      step();
      chk("up_q", q_fb, i % 10);
      chk("up_exp", expected, i % 10);
      chk("up_tc", tc, (i == 10) ? 1 : 0);
    end
    chk("up_err", err, 0);

    // 2: count down from 2 through the 0->9 wrap
    mode = 2'b10;
    step(); chk("dn_q1", q_fb, 1); chk("dn_tc1", tc, 0);
    step(); chk("dn_q0", q_fb, 0); chk("dn_tc0", tc, 0);
    step(); chk("dn_q9", q_fb, 9); chk("dn_tc9", tc, 1);
    step(); chk("dn_q8", q_fb, 8); chk("dn_tc8", tc, 0);
    step(); step(); step();
    chk("dn_q5", q_fb, 5);
    chk("dn_j54", j_out, 4'b0000);
    chk("dn_k54", k_out, 4'b0001);
    step(); chk("dn_q4", q_fb, 4);

    // 3: load, then clamped load
    mode = 2'b11; load_val = 4'd7; #1;
    chk("ld7_j", j_out, 4'b0011);
    chk("ld7_k", k_out, 4'b0000);
    chk("ld7_jk11", j_out & k_out, 0);
    step(); chk("ld7_q", q_fb, 7); chk("ld7_tc", tc, 0);
    load_val = 4'd13; #1;
    chk("ld13_j", j_out, 4'b1000);
    chk("ld13_k", k_out, 4'b0110);
    chk("ld13_jk11", j_out & k_out, 0);
    step(); chk("ld13_q", q_fb, 9); chk("ld13_tc", tc, 0);
    load_val = 4'd9; #1;
    chk("ldsame_j", j_out, 0);
    chk("ldsame_k", k_out, 0);
    load_val = 4'd3;
    step(); chk("ld3_q", q_fb, 3);
    chk("ld_err", err, 0);

    // 4: en=0 holds even in count-up mode
    en = 1'b0; mode = 2'b01; #1;
    chk("hold_j", j_out, 0);
    chk("hold_k", k_out, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_exp", expected, 3);
      chk("hold_q", q_fb, 3);
      chk("hold_tc", tc, 0);
    end

    // 5: illegal state injection and recovery
    en = 1'b1; ovr = 1'b1; ovr_val = 4'd12;
    step();
    ovr = 1'b0;
    chk("ill_q", q_fb, 12);
    chk("ill_flag", illegal, 1);
    chk("ill_err_pre", err, 0);
    chk("ill_j", j_out, 4'b0000);
    chk("ill_k", k_out, 4'b1100);
    step();
    chk("rec_q", q_fb, 0);
    chk("rec_tc", tc, 0);
    chk("rec_err", err, 1);
    chk("rec_ill", illegal, 0);
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("sticky_q", q_fb, i);
      chk("sticky_err", err, 1);
    end

    // 6: async reset mid-count at 6, off the edge
    #3;
    reset = 1'b1;
    #1;
    chk("arst_exp", expected, 0);
    chk("arst_tc", tc, 0);
    chk("arst_err", err, 0);
    chk("arst_q", q_fb, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("resume_q", q_fb, 1);
    chk("resume_exp", expected, 1);
    chk("resume_err", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/jk_count_sequencer.md
Name: jk_count_sequencer

Overview:
- Excitation/control stage placed directly upstream of a bank of WIDTH JK flip-flops.
- Reads the bank's Q outputs back and drives per-bit J/K so the bank behaves as a modulo-MOD up/down/loadable counter.
- Keeps a shadow copy of the expected bank state and flags any divergence.
- Emits a one-cycle terminal-count pulse on wrap-around.

Parameters:
- WIDTH, 4, number of JK flip-flops in the driven bank.
- MOD, 10, count modulus; legal range 2..2^WIDTH.

Ports:
- clk  input  1  clock; the JK bank uses the same clock and edge.
- reset  input  1  asynchronous, active-high reset; the JK bank shares this reset.
- en  input  1  advance enable; 0 = hold.
- mode  input  2  00 hold, 01 count up, 10 count down, 11 load.
- load_val  input  WIDTH  value applied when mode=11.
- q_fb  input  WIDTH  Q outputs fed back from the JK bank.
- j_out  output  WIDTH  J inputs to the JK bank, bit i drives flip-flop i.
- k_out  output  WIDTH  K inputs to the JK bank.
- expected  output  WIDTH  shadow register holding the state the bank must hold after the last edge.
- tc  output  1  registered one-cycle wrap pulse.
- illegal  output  1  combinational; high while q_fb >= MOD.
- err  output  1  sticky mismatch/illegal flag.

Behaviour:
- Reset (async, immediate): expected=0, tc=0, err=0.
  - j_out/k_out are combinational from q_fb; during reset they follow q_fb=0 and the inputs.
  - The JK bank resets to Q=0, so expected and q_fb agree on reset release.
- Next-value computation, nxt, from q_fb:
  - en=0 or mode=00: nxt=q_fb.
  - mode=01: nxt = (q_fb==MOD-1) ? 0 : q_fb+1.
  - mode=10: nxt = (q_fb==0) ? MOD-1 : q_fb-1.
  - mode=11: nxt = (load_val>=MOD) ? MOD-1 : load_val (clamp).
  - If q_fb>=MOD (illegal) and en=1 with mode 01/10: nxt=0 (recovery). Hold and load behave as above.
- Excitation per bit, fixed policy, never toggle, never J=K=1:
  - q=0 to n=0: J=0, K=0.
  - q=0 to n=1: J=1, K=0.
  - q=1 to n=0: J=0, K=1.
  - q=1 to n=1: J=0, K=0.
- j_out/k_out are purely combinational from q_fb, en, mode, load_val. Latency is zero: the bank's Q equals nxt after the next posedge.
- Shadow register: expected <= nxt every posedge.
- Checker, every posedge: if q_fb != expected, or illegal=1, then err <= 1.
  - err stays set until reset.
  - The check uses pre-edge values: q_fb and expected both reflect the previous edge.
- Terminal count: tc <= 1 for exactly one cycle when en=1 and either:
  - mode=01 and q_fb==MOD-1, or
  - mode=10 and q_fb==0.
  - Otherwise tc <= 0.
  - Load, hold, and illegal recovery never pulse tc.
- Simultaneous events:
  - mode changes take effect on the same cycle's J/K; there is no pipeline.
  - A load of a value equal to q_fb produces J=K=0 on all bits.
- Reset mid-count: all registers clear immediately. Counting resumes from 0 on the first posedge after reset deasserts.
- Arithmetic is WIDTH bits, unsigned. Wrap handling uses MOD explicitly, never natural 2^WIDTH overflow, unless MOD=2^WIDTH.

Test Plan:
1. Reset, then en=1, mode=01 for 12 cycles with a JK bank model attached. Require q_fb sequence 1..9,0,1,2; tc high for exactly the one cycle after the 9→0 edge; err=0.
2. From q_fb=0, mode=10, en=1. Require next state 9, tc pulse; then 8. From q_fb=5 going to 4, require j_out=0000, k_out=0001.
3. mode=11 with load_val=7, then load_val=13. Require 7, then clamped 9. Require no tc pulse and no bit with J=K=1.
4. en=0 with mode=01 for 5 cycles at q_fb=3. Require j_out=k_out=0, expected stays 3, tc=0.
5. Force the bank to 12 (illegal) while in mode=01. Require illegal=1; the next state is 0; err latches 1 and stays 1 after returning to legal states, until reset.
6. Assert reset mid-count at q_fb=6, asynchronously and off a clock edge. Require expected=0, tc=0, err=0 immediately; after release, counting resumes at 1.
